// File: rtl/gaussian_pyramid_sequencer.sv
// gaussian_pyramid_sequencer: feeds one raster frame plus flush rows into the pyramid
// and tags, filters and counts the Gaussian outputs that belong to that frame.
module gaussian_pyramid_sequencer #(
    parameter int IMG_WIDTH     = 800,
    parameter int IMG_HEIGHT    = 600,
    parameter int KERNEL_RADIUS = 3
) (
    input  logic       iclk,
    input  logic       irst,
    input  logic       iFrameStart,
    input  logic [7:0] iPixel,
    input  logic       iPixel_valid,
    output logic       oPixel_ready,
    output logic [8:0] oImagePixelData,
    input  logic       iGaussValid,
    output logic       oOutKeep,
    output logic [9:0] oOutRow,
    output logic [9:0] oOutCol,
    output logic       oBusy,
    output logic       oFrameDone
);
    localparam int FLUSH_N = KERNEL_RADIUS * IMG_WIDTH;
    localparam int TOTAL   = IMG_WIDTH * IMG_HEIGHT;
    localparam int FW      = $clog2(FLUSH_N + 1);
    localparam int CW      = $clog2(TOTAL + 1);
    localparam logic [9:0]    LAST_COL   = 10'(IMG_WIDTH - 1);
    localparam logic [9:0]    LAST_ROW   = 10'(IMG_HEIGHT - 1);
    localparam logic [FW-1:0] FLUSH_LAST = FW'(FLUSH_N - 1);
    localparam logic [FW-1:0] FLUSH_END  = FW'(FLUSH_N);
    localparam logic [CW-1:0] TOTAL_C    = CW'(TOTAL);
    localparam logic [CW-1:0] TOTAL_LAST = CW'(TOTAL - 1);

    typedef enum logic [1:0] {IDLE, STREAM, FLUSH, DRAIN} stateType;

    stateType      state;
    logic [9:0]    inRow, inCol, outRow, outCol, heldRow, heldCol;
    logic [FW-1:0] flushCnt, discardCnt;
    logic [CW-1:0] outCount;
    logic          firstFrame, active, accept, discard, keep;

    // Leading outputs of a follow-on frame are the previous frame's flush rows.
    always_comb begin
        active  = state != IDLE;
        accept  = iPixel_valid && state == STREAM;
        discard = iGaussValid && active && !firstFrame && discardCnt != FLUSH_END;
        keep    = iGaussValid && active && !discard && outCount != TOTAL_C;
    end

    assign oPixel_ready = state == STREAM;
    assign oBusy        = active;
    assign oOutKeep     = keep;
    assign oOutRow      = keep ? outRow : heldRow;
    assign oOutCol      = keep ? outCol : heldCol;

    always_ff @(posedge iclk) begin
        if (irst) begin
            state           <= IDLE;
            inRow           <= '0;
            inCol           <= '0;
            outRow          <= '0;
            outCol          <= '0;
            heldRow         <= '0;
            heldCol         <= '0;
            flushCnt        <= '0;
            discardCnt      <= '0;
            outCount        <= '0;
            firstFrame      <= 1'b1;
            oImagePixelData <= '0;
            oFrameDone      <= 1'b0;
        end else begin
            oFrameDone <= 1'b0;
            case (state)
                IDLE: begin
                    oImagePixelData <= '0;
                    if (iFrameStart) begin
                        state      <= STREAM;
                        inRow      <= '0;
                        inCol      <= '0;
                        outRow     <= '0;
                        outCol     <= '0;
                        flushCnt   <= '0;
                        discardCnt <= '0;
                        outCount   <= '0;
                    end
                end
                STREAM: begin
                    oImagePixelData <= accept ? {1'b1, iPixel} : 9'h000;
                    if (accept) begin
                        if (inCol == LAST_COL) begin
                            inCol <= '0;
                            inRow <= inRow + 10'd1;
                            if (inRow == LAST_ROW) state <= FLUSH;
                        end else begin
                            inCol <= inCol + 10'd1;
                        end
                    end
                end
                FLUSH: begin
                    oImagePixelData <= 9'h100;
                    flushCnt        <= flushCnt + FW'(1);
                    if (flushCnt == FLUSH_LAST) state <= DRAIN;
                end
                DRAIN: begin
                    oImagePixelData <= '0;
                    if (outCount == TOTAL_C) state <= IDLE;
                end
            endcase
            if (discard) discardCnt <= discardCnt + FW'(1);
            if (keep) begin
                heldRow  <= outRow;
                heldCol  <= outCol;
                outCount <= outCount + CW'(1);
                if (outCol == LAST_COL) begin
                    outCol <= '0;
                    outRow <= outRow + 10'd1;
                end else begin
                    outCol <= outCol + 10'd1;
                end
                if (outCount == TOTAL_LAST) begin
                    oFrameDone <= 1'b1;
                    firstFrame <= 1'b0;
                end
            end
        end
    end
endmodule

// File: tb/tb_gaussian_pyramid_sequencer.sv
// tb_gaussian_pyramid_sequencer: randomized frames against a count-based reference model
// of the sequencer on an 8x4 image with a 3-line flush.
module tb_gaussian_pyramid_sequencer;
    localparam int W = 8, H = 4, R = 3, TOT = W * H, FL = R * W;

    logic       iclk = 1'b0, irst = 1'b1, iFrameStart = 1'b0, iPixel_valid = 1'b0, iGaussValid = 1'b0;
    logic [7:0] iPixel = 8'h00;
    logic       oPixel_ready, oOutKeep, oBusy, oFrameDone;
    logic [8:0] oImagePixelData;
    logic [9:0] oOutRow, oOutCol;

    gaussian_pyramid_sequencer #(.IMG_WIDTH(W), .IMG_HEIGHT(H), .KERNEL_RADIUS(R)) dut (
        .iclk(iclk), .irst(irst), .iFrameStart(iFrameStart), .iPixel(iPixel),
        .iPixel_valid(iPixel_valid), .oPixel_ready(oPixel_ready),
        .oImagePixelData(oImagePixelData), .iGaussValid(iGaussValid), .oOutKeep(oOutKeep),
        .oOutRow(oOutRow), .oOutCol(oOutCol), .oBusy(oBusy), .oFrameDone(oFrameDone)
    );

    always #5 iclk = ~iclk;

    // phase: 0 idle, 1 streaming, 2 flushing, 3 draining
    int         phase, accepted, flushed, discarded, kept, checks, errors;
    bit         first, expDone;
    logic [8:0] expBus;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic modelReset();
        phase = 0; accepted = 0; flushed = 0; discarded = 0; kept = 0;
        first = 1'b1; expBus = 9'h000; expDone = 1'b0;
    endtask

    task automatic step(input bit rst, input bit fs, input bit pv, input bit gv, input logic [7:0] pix);
        bit acc, disc, keep;
        @(negedge iclk);
        irst = rst; iFrameStart = fs; iPixel_valid = pv; iGaussValid = gv; iPixel = pix;
        #1;
        acc  = phase == 1 && pv;
        disc = gv && phase != 0 && !first && discarded < FL;
        keep = gv && phase != 0 && !disc && kept < TOT;
        check("ready", oPixel_ready, phase == 1);
        check("bus", oImagePixelData, expBus);
        check("keep", oOutKeep, keep);
        check("busy", oBusy, phase != 0);
        check("done", oFrameDone, expDone);
        if (keep) begin
            check("row", oOutRow, kept / W);
            check("col", oOutCol, kept % W);
        end
        if (rst) begin
            modelReset();
        end else begin
            expBus  = acc ? {1'b1, pix} : (phase == 2 ? 9'h100 : 9'h000);
            expDone = keep && kept == TOT - 1;
            case (phase)
                0: if (fs) begin phase = 1; accepted = 0; flushed = 0; discarded = 0; kept = 0; end
                1: if (acc && accepted == TOT - 1) phase = 2;
                2: if (flushed == FL - 1) phase = 3;
                default: if (kept == TOT) phase = 0;
            endcase
            if (phase == 2 && !acc) flushed++;
            if (expDone) first = 1'b0;
            if (disc) discarded++;
            if (keep) kept++;
            if (acc) accepted++;
        end
    endtask

    // mode 0: continuous pixels, 1: every other cycle, 2: random; abortAt>=0 resets mid-frame
    task automatic runFrame(input int mode, input int abortAt);
        bit started = 1'b0, finished = 1'b0, fs, pv, gv, lastPending;
        for (int c = 0; c < 3000 && !finished; c++) begin
            if (abortAt >= 0 && phase == 1 && accepted == abortAt) begin
                step(1'b1, 1'b0, 1'b0, 1'b0, 8'h00);
                finished = 1'b1;
            end else begin
                fs = (phase == 0 && !started) || expDone || (phase != 0 && $urandom_range(7) == 0);
                pv = mode == 0 ? 1'b1 : (mode == 1 ? c[0] : 1'($urandom_range(1)));
                lastPending = (first || discarded >= FL) && kept == TOT - 1 && phase != 3;
                gv = phase == 0 ? ($urandom_range(3) == 0) : (1'($urandom_range(1)) && !lastPending);
                step(1'b0, fs, pv, gv, 8'($urandom));
                if (phase != 0) started = 1'b1;
                if (started && phase == 0) finished = 1'b1;
            end
        end
        check("frame_timeout", finished, 1'b1);
    endtask

    initial begin
        checks = 0;
        errors = 0;
        modelReset();
        repeat (3) @(posedge iclk);
        @(negedge iclk);
        #1;
        check("rst_bus", oImagePixelData, 9'h000);
        check("rst_ready", oPixel_ready, 1'b0);
        check("rst_keep", oOutKeep, 1'b0);
        check("rst_row", oOutRow, 10'd0);
        check("rst_col", oOutCol, 10'd0);
        check("rst_busy", oBusy, 1'b0);
        check("rst_done", oFrameDone, 1'b0);
        runFrame(0, -1);
        runFrame(1, -1);
        runFrame(2, 2 * W + 5);
        step(1'b0, 1'b0, 1'b0, 1'b0, 8'h00);
        check("abort_row", oOutRow, 10'd0);
        check("abort_col", oOutCol, 10'd0);
        runFrame(2, -1);
        runFrame(1, -1);
        runFrame(2, -1);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
